strip_placer_pipe: RTL and testbench



---
 rtl/strip_placer_pkg.sv | 17 +
 rtl/strip_placer_pipe_strip_select.sv | 45 ++++
 rtl/strip_placer_pipe.sv | 122 ++++++++++++
 tb/tb_strip_placer_pipe.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/strip_placer_pkg.sv
// strip_placer_pkg: shared constants for the strip placement pipeline.
// Holds the default geometry, the per-strip height and y-base tables, and
// the strike coordinate and strike-counter saturation value for the default widths.
package strip_placer_pkg;
    localparam int NUM_STRIPS_DEF = 14;
    localparam int CANVAS_W_DEF   = 128;
    localparam int COORD_W_DEF    = 8;
    localparam int STRIKE_W_DEF   = 4;

    localparam logic [7:0] STRIP_H [14] = '{8'd4, 8'd4, 8'd5, 8'd5, 8'd6, 8'd7, 8'd8,
                                            8'd9, 8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd16};
    localparam logic [7:0] STRIP_Y [14] = '{8'd0, 8'd4, 8'd8, 8'd13, 8'd18, 8'd24, 8'd31,
                                            8'd39, 8'd48, 8'd58, 8'd69, 8'd81, 8'd94, 8'd108};

    localparam logic [COORD_W_DEF-1:0]  STRIKE_COORD = '1;
    localparam logic [STRIKE_W_DEF-1:0] STRIKE_SAT   = '1;
endpackage

// File: rtl/strip_placer_pipe_strip_select.sv
// strip_select: combinational strip choice for one rectangle orientation.
// Ports: width_i/height_i  rectangle dimensions
//        occ_i             per-strip occupancy
//        sel_id_o          chosen strip (least occupied of the height class, lowest index on tie)
//        sel_occ_o         occupancy of the chosen strip (placement x)
//        fit_o             rectangle is non-degenerate, has a class and fits the chosen strip
module strip_select
    import strip_placer_pkg::*;
#(
    parameter int NUM_STRIPS = NUM_STRIPS_DEF,
    parameter int CANVAS_W   = CANVAS_W_DEF,
    parameter int DIM_W      = 5,
    parameter int COORD_W    = COORD_W_DEF,
    parameter int ID_W       = $clog2(NUM_STRIPS)
) (
    input  logic [DIM_W-1:0]                     width_i,
    input  logic [DIM_W-1:0]                     height_i,
    input  logic [NUM_STRIPS-1:0][COORD_W-1:0]   occ_i,
    output logic [ID_W-1:0]                      sel_id_o,
    output logic [COORD_W-1:0]                   sel_occ_o,
    output logic                                 fit_o
);
    logic [8:0] w_cls;
    logic       w_found;

    always_comb begin
        // all-ones class never matches a table entry, so "no class" leaves w_found low
        w_cls = '1;
        for (int k = 0; k < NUM_STRIPS; k++)
            if ({1'b0, STRIP_H[k]} >= 9'(height_i) && {1'b0, STRIP_H[k]} < w_cls)
                w_cls = {1'b0, STRIP_H[k]};
        w_found   = 1'b0;
        sel_id_o  = '0;
        sel_occ_o = '0;
        for (int k = 0; k < NUM_STRIPS; k++)
            if ({1'b0, STRIP_H[k]} == w_cls && (!w_found || occ_i[k] < sel_occ_o)) begin
                w_found   = 1'b1;
                sel_id_o  = ID_W'(k);
                sel_occ_o = occ_i[k];
            end
        // one extra bit so occupancy + width cannot wrap
        fit_o = w_found && width_i != '0 && height_i != '0 &&
                ({1'b0, sel_occ_o} + (COORD_W+1)'(width_i) <= (COORD_W+1)'(CANVAS_W));
    end
endmodule

// File: rtl/strip_placer_pipe.sv
// strip_placer_pipe: two-stage valid/ready pipeline placing rectangles into canvas strips.
// Ports: clk_i, rst_i (sync, active low)
//        in_valid_i/in_ready_o/in_width_i/in_height_i   request handshake
//        out_valid_o/out_ready_i                        result handshake
//        index_x_o/index_y_o                            lower-left placement, all-ones on strike
//        strike_flag_o                                  result is a strike
//        strike_o                                       saturating strike count
//        rotated_o                                      placed in swapped orientation (STRIP_PLACER_ROTATE_EN only)
// Macro: STRIP_PLACER_ROTATE_EN retries a striking request with width and height swapped.
module strip_placer_pipe
    import strip_placer_pkg::*;
#(
    parameter int NUM_STRIPS = NUM_STRIPS_DEF,
    parameter int CANVAS_W   = CANVAS_W_DEF,
    parameter int DIM_W      = 5,
    parameter int COORD_W    = COORD_W_DEF,
    parameter int STRIKE_W   = STRIKE_W_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [DIM_W-1:0]    in_width_i,
    input  logic [DIM_W-1:0]    in_height_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [COORD_W-1:0]  index_x_o,
    output logic [COORD_W-1:0]  index_y_o,
    output logic                strike_flag_o,
    output logic [STRIKE_W-1:0] strike_o
`ifdef STRIP_PLACER_ROTATE_EN
    ,
    output logic                rotated_o
`endif
);
    localparam int ID_W = $clog2(NUM_STRIPS);

    logic                             r_s1_valid;
    logic [DIM_W-1:0]                 r_s1_w;
    logic [DIM_W-1:0]                 r_s1_h;
    logic [NUM_STRIPS-1:0][COORD_W-1:0] r_occ;

    logic               w_adv;
    logic [ID_W-1:0]    w_id0;
    logic [COORD_W-1:0] w_occ0;
    logic               w_fit0;
    logic [ID_W-1:0]    w_id;
    logic [COORD_W-1:0] w_occ;
    logic [DIM_W-1:0]   w_wid;
    logic               w_place;

    assign w_adv      = !out_valid_o || out_ready_i;
    assign in_ready_o = rst_i && (!r_s1_valid || w_adv);

    strip_select #(.NUM_STRIPS(NUM_STRIPS), .CANVAS_W(CANVAS_W), .DIM_W(DIM_W),
                   .COORD_W(COORD_W), .ID_W(ID_W)) u_sel (
        .width_i(r_s1_w), .height_i(r_s1_h), .occ_i(r_occ),
        .sel_id_o(w_id0), .sel_occ_o(w_occ0), .fit_o(w_fit0));

`ifdef STRIP_PLACER_ROTATE_EN
    logic [ID_W-1:0]    w_id1;
    logic [COORD_W-1:0] w_occ1;
    logic               w_fit1;
    logic               w_rot;

    strip_select #(.NUM_STRIPS(NUM_STRIPS), .CANVAS_W(CANVAS_W), .DIM_W(DIM_W),
                   .COORD_W(COORD_W), .ID_W(ID_W)) u_sel_rot (
        .width_i(r_s1_h), .height_i(r_s1_w), .occ_i(r_occ),
        .sel_id_o(w_id1), .sel_occ_o(w_occ1), .fit_o(w_fit1));

    // a fitting rotated orientation implies both dimensions are non-zero
    assign w_rot   = !w_fit0 && w_fit1;
    assign w_place = w_fit0 || w_rot;
    assign w_id    = w_rot ? w_id1 : w_id0;
    assign w_occ   = w_rot ? w_occ1 : w_occ0;
    assign w_wid   = w_rot ? r_s1_h : r_s1_w;
`else
    assign w_place = w_fit0;
    assign w_id    = w_id0;
    assign w_occ   = w_occ0;
    assign w_wid   = r_s1_w;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_s1_valid    <= 1'b0;
            r_s1_w        <= '0;
            r_s1_h        <= '0;
            r_occ         <= '0;
            out_valid_o   <= 1'b0;
            index_x_o     <= '0;
            index_y_o     <= '0;
            strike_flag_o <= 1'b0;
            strike_o      <= '0;
`ifdef STRIP_PLACER_ROTATE_EN
            rotated_o     <= 1'b0;
`endif
        end else begin
            if (in_ready_o) begin
                r_s1_valid <= in_valid_i;
                r_s1_w     <= in_width_i;
                r_s1_h     <= in_height_i;
            end
            if (w_adv) begin
                out_valid_o <= r_s1_valid;
                if (r_s1_valid) begin
                    index_x_o     <= w_place ? w_occ : COORD_W'(STRIKE_COORD);
                    index_y_o     <= w_place ? COORD_W'(STRIP_Y[w_id]) : COORD_W'(STRIKE_COORD);
                    strike_flag_o <= !w_place;
`ifdef STRIP_PLACER_ROTATE_EN
                    rotated_o     <= w_rot;
`endif
                    // occupancy updates on the S1->S2 edge so the next S1 entry sees it
                    if (w_place)
                        r_occ[w_id] <= w_occ + COORD_W'(w_wid);
                    else if (strike_o != STRIKE_W'(STRIKE_SAT))
                        strike_o <= strike_o + STRIKE_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_strip_placer_pipe.sv
// tb_strip_placer_pipe: directed self-checking bench for strip_placer_pipe.
module tb_strip_placer_pipe;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [4:0] in_width = '0;
    logic [4:0] in_height = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] index_x;
    logic [7:0] index_y;
    logic       strike_flag;
    logic [3:0] strike;
    int         checks = 0;
    int         errors = 0;
`ifdef STRIP_PLACER_ROTATE_EN
    logic       rotated;
`endif

    always #5 clk = ~clk;

    strip_placer_pipe dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_width_i(in_width), .in_height_i(in_height),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .index_x_o(index_x), .index_y_o(index_y),
        .strike_flag_o(strike_flag), .strike_o(strike)
`ifdef STRIP_PLACER_ROTATE_EN
        , .rotated_o(rotated)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic place(input string tag, input logic [4:0] w, input logic [4:0] h,
                         input logic [7:0] ex, input logic [7:0] ey, input logic ef,
                         input logic [3:0] es, input logic erot);
        int n;
        @(negedge clk);
        in_valid = 1'b1; in_width = w; in_height = h;
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        chk({tag, "_rdy"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        chk({tag, "_vld"}, out_valid, 1);
        chk({tag, "_x"}, index_x, ex);
        chk({tag, "_y"}, index_y, ey);
        chk({tag, "_flag"}, strike_flag, ef);
        chk({tag, "_strike"}, strike, es);
`ifdef STRIP_PLACER_ROTATE_EN
        chk({tag, "_rot"}, rotated, erot);
`else
        if (erot) $display("note: %s expects rotation, not built", tag);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ex [5];
        ex[0] = 8'd0; ex[1] = 8'd31; ex[2] = 8'd62; ex[3] = 8'd93; ex[4] = 8'hFF;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_vld", out_valid, 0);
        chk("rst_x", index_x, 0);
        chk("rst_y", index_y, 0);
        chk("rst_flag", strike_flag, 0);
        chk("rst_strike", strike, 0);
        chk("rst_rdy", in_ready, 0);
        rst = 1'b1;

        // basic placements and min-occupancy selection in class 4
        place("p1", 5'd10, 5'd3, 8'd0, 8'd0, 1'b0, 4'd0, 1'b0);
        place("p2", 5'd5, 5'd4, 8'd0, 8'd4, 1'b0, 4'd0, 1'b0);
        place("p3", 5'd2, 5'd4, 8'd5, 8'd4, 1'b0, 4'd0, 1'b0);
        place("p4", 5'd6, 5'd3, 8'd7, 8'd4, 1'b0, 4'd0, 1'b0);

        // five back-to-back into strip 13; results on consecutive cycles
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i == 1) chk("b2b_lat", out_valid, 0);
            if (i >= 2) begin
                chk($sformatf("b2b%0d_vld", i-2), out_valid, 1);
                chk($sformatf("b2b%0d_x", i-2), index_x, ex[i-2]);
                chk($sformatf("b2b%0d_y", i-2), index_y, (i == 6) ? 8'hFF : 8'd108);
                chk($sformatf("b2b%0d_flag", i-2), strike_flag, (i == 6) ? 1 : 0);
                chk($sformatf("b2b%0d_strike", i-2), strike, (i == 6) ? 1 : 0);
            end
            if (i < 5) chk($sformatf("b2b%0d_rdy", i), in_ready, 1);
            in_valid = (i < 5); in_width = 5'd31; in_height = 5'd16;
        end
        in_valid = 1'b0;

        // strikes: no class, zero dimension, then saturation
        place("s_nocls", 5'd20, 5'd20, 8'hFF, 8'hFF, 1'b1, 4'd2, 1'b0);
        place("s_zero", 5'd0, 5'd5, 8'hFF, 8'hFF, 1'b1, 4'd3, 1'b0);
        for (int i = 0; i < 16; i++)
            place($sformatf("s_sat%0d", i), 5'd0, 5'd5, 8'hFF, 8'hFF, 1'b1,
                  (i < 12) ? 4'(4 + i) : 4'd15, 1'b0);

        // back-pressure: two requests held behind a stalled output
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_width = 5'd3; in_height = 5'd5;
        chk("bp_rdyA", in_ready, 1);
        @(negedge clk);
        in_width = 5'd4;
        chk("bp_rdyB", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d_vld", i), out_valid, 1);
            chk($sformatf("bp%0d_x", i), index_x, 0);
            chk($sformatf("bp%0d_y", i), index_y, 8'd8);
            chk($sformatf("bp%0d_rdy", i), in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bpB_vld", out_valid, 1);
        chk("bpB_x", index_x, 0);
        chk("bpB_y", index_y, 8'd13);
        chk("bpB_flag", strike_flag, 0);
        @(negedge clk);
        chk("bp_nodup", out_valid, 0);

        // reset pulse with both stages full
        out_ready = 1'b0; in_valid = 1'b1; in_width = 5'd1; in_height = 5'd5;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        chk("rp_pre_vld", out_valid, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("rp_vld", out_valid, 0);
        chk("rp_strike", strike, 0);
        chk("rp_rdy", in_ready, 0);
        chk("rp_x", index_x, 0);
        rst = 1'b1; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rp_discard", out_valid, 0);
        place("rp_after", 5'd4, 5'd4, 8'd0, 8'd0, 1'b0, 4'd0, 1'b0);

`ifdef STRIP_PLACER_ROTATE_EN
        for (int i = 0; i < 4; i++)
            place($sformatf("r_fill%0d", i), 5'd31, 5'd16, ex[i], 8'd108, 1'b0, 4'd0, 1'b0);
        place("r_unrot", 5'd16, 5'd10, 8'd0, 8'd48, 1'b0, 4'd0, 1'b0);
        place("r_unrot2", 5'd11, 5'd6, 8'd0, 8'd18, 1'b0, 4'd0, 1'b0);
        place("r_nofit", 5'd5, 5'd16, 8'd0, 8'd8, 1'b0, 4'd0, 1'b1);
        place("r_nocls", 5'd4, 5'd20, 8'd0, 8'd4, 1'b0, 4'd0, 1'b1);
        place("r_zero", 5'd0, 5'd5, 8'hFF, 8'hFF, 1'b1, 4'd1, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
